// File: rtl/d_sram_bridge_pkg.sv
// Shared types and codes for the data-side SRAM bridge.
package d_sram_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // True for the byte-strobe patterns the datapath is allowed to issue.
  function automatic logic wen_legal(input logic [3:0] wen);
    case (wen)
      4'b0000, 4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: wen_legal = 1'b1;
      default:                            wen_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/d_size_enc.sv
// Byte-strobe to {write, transfer size} encoder for the bridge request.
module d_size_enc
  import d_sram_bridge_pkg::*;
(
  input  logic [3:0] wen,
  output logic       wr,
  output logic [1:0] size
);

  always_comb begin
    wr   = |wen;
    size = SZ_WORD;
    case (wen)
      4'b0011, 4'b1100:                   size = SZ_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SZ_BYTE;
      default:                            size = SZ_WORD;
    endcase
  end

endmodule

// File: rtl/d_sram_bridge.sv
// MEM-stage SRAM-style access to sram-like split-transaction bridge, one
// outstanding request, stalls the pipeline until the access completes.
module d_sram_bridge
  import d_sram_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_en,
  input  logic [DATA_W/8-1:0] cpu_wen,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                d_stall,
  input  logic                longest_stall,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W-1:0]   data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                enc_wr;
  logic [1:0]          enc_size;

  d_size_enc u_size_enc (
    .wen  (cpu_wen),
    .wr   (enc_wr),
    .size (enc_size)
  );

  // The strobes are encoded at latch time, so only {wr, size} is held
  // rather than the raw wen; data_wr is still |wen of the accepted access.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_en) begin
          addr_d  = enc_wr ? cpu_addr : {cpu_addr[ADDR_W-1:2], 2'b00};
          wdata_d = cpu_wdata;
          wr_d    = enc_wr;
          size_d  = enc_size;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (data_addr_ok) begin
          if (data_data_ok) begin
            if (!wr_q) rdata_d = data_rdata;
            state_d = S_DONE;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (data_data_ok) begin
          if (!wr_q) rdata_d = data_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!longest_stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_req   = (state_q == S_ADDR);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign cpu_rdata  = rdata_q;
  assign d_stall    = cpu_en & (state_q != S_DONE);

  a_wen_legal: assert property (@(posedge clk) disable iff (!rst)
    (state_q == S_IDLE && cpu_en) |-> wen_legal(cpu_wen[3:0]));

endmodule

// File: tb/tb_d_sram_bridge.sv
// Randomized bench for d_sram_bridge with a transaction-level memory model.
module tb_d_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        d_stall;
  logic        longest_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  always #5 clk = ~clk;

  d_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_en        (cpu_en),
    .cpu_wen       (cpu_wen),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .d_stall       (d_stall),
    .longest_stall (longest_stall),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_size     (data_size),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_addr_ok  (data_addr_ok),
    .data_data_ok  (data_data_ok),
    .data_rdata    (data_rdata)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_size(input logic [3:0] wen);
    if ($countones(wen) == 1) return 2'd0;
    if (wen == 4'b0011 || wen == 4'b1100) return 2'd1;
    return 2'd2;
  endfunction

  // One CPU access: memory accepts after `a` wait cycles of req, answers
  // `d` cycles after acceptance (0 = same cycle), DONE held for `hold` cycles.
  task automatic access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] resp, input int unsigned a, input int unsigned d,
                        input int unsigned hold);
    logic [31:0] rd_before = exp_rdata;
    int unsigned stalls = 0, reqs = 0, waited = 0, since = 0, cyc = 0;
    bit accepted = 0, responded = 0, finished = 0, seen_done = 0;
    cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
    while (!finished && cyc < 200) begin
      cyc++;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
      if (data_req) begin
        if (accepted) reqs++;
        else if (waited == a) begin
          data_addr_ok = 1'b1; accepted = 1; reqs++;
          check("req_addr", data_addr, (wen == 4'b0) ? (addr & ~32'h3) : addr);
          check("req_wr", data_wr, (wen != 4'b0));
          check("req_size", data_size, ref_size(wen));
          check("req_wdata", data_wdata, wdata);
          if (d == 0) begin data_data_ok = 1'b1; data_rdata = resp; responded = 1; end
        end else begin
          waited++;
          data_data_ok = 1'($urandom_range(0, 1));
        end
      end else if (accepted && !responded) begin
        since++;
        if (since == d) begin data_data_ok = 1'b1; data_rdata = resp; responded = 1; end
      end
      @(negedge clk);
      if (d_stall) begin
        stalls++;
        check("rdata_hold", cpu_rdata, rd_before);
        longest_stall = 1'b1;
      end else begin
        if (!seen_done) begin
          seen_done = 1;
          if (wen == 4'b0) exp_rdata = resp;
          check("stall_len", stalls, 2 + a + d);
        end
        check("rdata_done", cpu_rdata, exp_rdata);
        check("req_in_done", data_req, 1'b0);
        if (hold > 0) begin hold--; longest_stall = 1'b1; end
        else begin longest_stall = 1'b0; finished = 1; end
      end
      @(posedge clk); #1;
    end
    if (!finished) check("timeout", 1'b0, 1'b1);
    check("req_count", reqs, 1);
  endtask

  task automatic idle(input int unsigned n);
    cpu_en = 1'b0; cpu_wen = 4'($urandom); longest_stall = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("idle_stall", d_stall, 1'b0);
      check("idle_req", data_req, 1'b0);
      check("idle_rdata", cpu_rdata, exp_rdata);
      @(posedge clk); #1;
    end
  endtask

  logic [3:0] legal_wen [9] = '{4'b0000, 4'b1111, 4'b0011, 4'b1100,
                                4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};

  initial begin
    rst = 1'b0; cpu_en = 1'b0; cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0;
    longest_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    exp_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_req", data_req, 1'b0);
    check("rst_wr", data_wr, 1'b0);
    check("rst_size", data_size, 2'd0);
    check("rst_addr", data_addr, 32'h0);
    check("rst_wdata", data_wdata, 32'h0);
    check("rst_stall", d_stall, 1'b0);
    @(posedge clk); #1; rst = 1'b1;
    idle(2);

    access(4'b0000, 32'h1000_0006, 32'h1234_5678, 32'hDEAD_BEEF, 1, 2, 0);
    idle(1);
    access(4'b0100, 32'h1000_0006, 32'h00AB_0000, 32'h5555_5555, 0, 1, 0);
    access(4'b0000, 32'h0000_0100, 32'h0, 32'hCAFE_0001, 0, 0, 0);
    access(4'b0000, 32'h0000_0104, 32'h0, 32'hCAFE_0002, 2, 1, 3);
    access(4'b0000, 32'h0000_0020, 32'h0, 32'hA5A5_0020, 1, 1, 0);
    access(4'b1100, 32'h0000_0022, 32'hBEEF_0000, 32'h7777_7777, 0, 2, 0);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      access(legal_wen[$urandom_range(0, 8)], $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end

    // Reset while waiting in DATA for a read response.
    access(4'b0000, 32'h0000_0300, 32'h0, 32'h1357_9BDF, 0, 0, 0);
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_0040;
    @(posedge clk); #1;
    check("pre_rst_req", data_req, 1'b1);
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    check("pre_rst_stall", d_stall, 1'b1);
    rst = 1'b0; #1;
    exp_rdata = '0;
    check("mid_rst_req", data_req, 1'b0);
    check("mid_rst_stall", d_stall, 1'b1);
    check("mid_rst_rdata", cpu_rdata, 32'h0);
    check("mid_rst_addr", data_addr, 32'h0);
    cpu_en = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    data_data_ok = 1'b1; data_rdata = 32'hFFFF_0000;
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    @(negedge clk);
    check("late_ok_rdata", cpu_rdata, 32'h0);
    check("late_ok_req", data_req, 1'b0);
    @(posedge clk); #1;
    access(4'b0000, 32'h0000_0044, 32'h0, 32'h2468_ACE0, 1, 0, 1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
